// File: rtl/registrador_arb_pkg.sv
// registrador_arb_pkg: shared types, register width and round-robin pick helper
// for the Registrador write arbiter.
package registrador_arb_pkg;

    typedef enum logic [1:0] {CLEAR, IDLE, COMMIT} state_t;

    localparam int REG_W = 16;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Scanning downwards lets the nearest requester after ptr overwrite farther ones.
    function automatic pick_t rr_pick(logic [7:0] valid, logic [2:0] ptr, int n);
        pick_t p;
        int    i;
        p = '0;
        for (int k = 7; k >= 0; k--) begin
            i = (int'(ptr) + k) % n;
            if (k < n && valid[i]) begin
                p.found = 1'b1;
                p.idx   = 3'(i);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/registrador_write_arbiter_registrador.sv
// registrador: 16-bit load-enabled storage register with no reset.
module registrador
    import registrador_arb_pkg::*;
(
    input  logic             clock,
    input  logic             load,
    input  logic [REG_W-1:0] d,
    output logic [REG_W-1:0] q
);

    always_ff @(posedge clock)
        if (load) q <= d;

endmodule

// File: rtl/registrador_write_arbiter.sv
// registrador_write_arbiter: round-robin valid/ready arbiter that clears, accepts
// and commits writes into one shared Registrador.
module registrador_write_arbiter
    import registrador_arb_pkg::*;
#(
    parameter int  NREQ = 4,
    parameter int  CNTW = 8,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [16*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [REG_W-1:0]     rd_data,
    output logic                 data_valid,
    output logic                 busy,
    output logic [IW-1:0]        last_writer,
    output logic [CNTW-1:0]      wr_count
);

    state_t           state;
    logic [IW-1:0]    rr_ptr, grant, win;
    logic             lock_l, load;
    logic [REG_W-1:0] staged, reg_in;
    pick_t            pick;

    assign pick      = rr_pick(8'(req_valid), 3'(rr_ptr), NREQ);
    assign win       = IW'(pick.idx);
    assign req_ready = (state == IDLE && pick.found) ? NREQ'(1) << win : '0;
    assign busy      = state != IDLE;
    assign load      = state != IDLE;
    assign reg_in    = state == COMMIT ? staged : '0;

    registrador u_reg (
        .clock (clock),
        .load  (load),
        .d     (reg_in),
        .q     (rd_data)
    );

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state       <= CLEAR;
            rr_ptr      <= '0;
            grant       <= '0;
            lock_l      <= 1'b0;
            staged      <= '0;
            last_writer <= '0;
            wr_count    <= '0;
            data_valid  <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    state      <= IDLE;
                    data_valid <= 1'b1;
                end
                IDLE: if (pick.found) begin
                    staged <= req_data[16*win +: 16];
                    grant  <= win;
                    lock_l <= req_lock[win];
                    state  <= COMMIT;
                end
                COMMIT: begin
                    last_writer <= grant;
                    wr_count    <= wr_count + 1'b1;
                    rr_ptr      <= lock_l ? grant : (grant == IW'(NREQ-1) ? '0 : grant + 1'b1);
                    state       <= IDLE;
                end
                default: state <= CLEAR;
            endcase
        end

endmodule

// File: tb/tb_registrador_write_arbiter.sv
// tb_registrador_write_arbiter: directed and random stimulus checked against a
// transaction-level model of the round-robin write arbiter.
module tb_registrador_write_arbiter;

    localparam int M_CLR = 0, M_IDLE = 1, M_CMT = 2;

    logic        clock, reset_n;
    logic [3:0]  req_valid, req_lock, req_ready;
    logic [15:0] data [4];
    logic [63:0] req_data;
    logic [15:0] rd_data;
    logic        data_valid, busy;
    logic [1:0]  last_writer;
    logic [7:0]  wr_count;

    int total = 0, bad = 0;

    int         ph;
    int         m_ptr, m_g, m_lw, m_cnt;
    logic       m_lk, m_dv, m_rdk;
    logic [15:0] m_rd, m_stg;
    logic [3:0]  m_acc;

    assign req_data = {data[3], data[2], data[1], data[0]};

    registrador_write_arbiter #(.NREQ(4), .CNTW(8)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_lock    (req_lock),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rd_data     (rd_data),
        .data_valid  (data_valid),
        .busy        (busy),
        .last_writer (last_writer),
        .wr_count    (wr_count)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Winner = valid requester with the smallest forward distance from the pointer.
    function automatic int winner(logic [3:0] v, int p);
        int best = -1, bd = 99, d;
        for (int i = 0; i < 4; i++)
            if (v[i]) begin
                d = (i - p + 4) % 4;
                if (d < bd) begin
                    bd = d;
                    best = i;
                end
            end
        return best;
    endfunction

    function automatic logic [3:0] exp_ready();
        int w = winner(req_valid, m_ptr);
        return (ph == M_IDLE && w >= 0) ? 4'(1 << w) : 4'b0;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        int w;
        m_acc = '0;
        if (!reset_n) begin
            ph = M_CLR; m_ptr = 0; m_lw = 0; m_cnt = 0; m_dv = 0; m_rdk = 0; m_g = 0; m_lk = 0;
        end else if (ph == M_CLR) begin
            m_rd = 16'h0000; m_rdk = 1; m_dv = 1; ph = M_IDLE;
        end else if (ph == M_IDLE) begin
            w = winner(req_valid, m_ptr);
            if (w >= 0) begin
                m_stg = data[w]; m_g = w; m_lk = req_lock[w]; m_acc[w] = 1'b1; ph = M_CMT;
            end
        end else begin
            m_rd = m_stg; m_lw = m_g; m_cnt = (m_cnt + 1) % 256;
            m_ptr = m_lk ? m_g : (m_g + 1) % 4;
            ph = M_IDLE;
        end
    end

    always @(negedge clock) begin
        chk("busy", 32'(busy), 32'(ph != M_IDLE));
        chk("data_valid", 32'(data_valid), 32'(m_dv));
        chk("wr_count", 32'(wr_count), 32'(m_cnt));
        chk("last_writer", 32'(last_writer), 32'(m_lw));
        chk("req_ready", 32'(req_ready), 32'(exp_ready()));
        if (m_rdk) chk("rd_data", 32'(rd_data), 32'(m_rd));
    end

    task automatic do_reset();
        reset_n = 0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1;
        @(negedge clock);
        chk("clear_busy", 32'(busy), 32'd1);
        chk("clear_dv", 32'(data_valid), 32'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_grant(output int idx, output int cyc);
        idx = -1;
        cyc = 0;
        for (int n = 0; n < 20 && idx < 0; n++) begin
            @(negedge clock);
            cyc++;
            for (int i = 0; i < 4; i++) if (req_ready[i]) idx = i;
        end
        if (idx < 0) chk("grant_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int idx, cyc;
        int exp3 [5] = '{0, 1, 2, 3, 0};
        reset_n = 0; req_valid = 0; req_lock = 0;
        for (int i = 0; i < 4; i++) data[i] = 16'h0;
        do_reset();
        @(negedge clock);
        chk("t1_rd", 32'(rd_data), 32'h0);
        chk("t1_dv", 32'(data_valid), 32'd1);
        chk("t1_cnt", 32'(wr_count), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        @(posedge clock);
        #1 req_valid = 4'b0001; data[0] = 16'hABCD;
        @(negedge clock);
        chk("t2_ready", 32'(req_ready), 32'h1);
        @(posedge clock);
        #1 req_valid = 0;
        @(negedge clock);
        chk("t2_ready_off", 32'(req_ready), 32'h0);
        chk("t2_busy", 32'(busy), 32'd1);
        @(negedge clock);
        chk("t2_rd", 32'(rd_data), 32'hABCD);
        chk("t2_lw", 32'(last_writer), 32'd0);
        chk("t2_cnt", 32'(wr_count), 32'd1);
        @(posedge clock);
        #1;
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(idx, cyc);
            chk("t3_grant", 32'(idx), 32'(exp3[k]));
            if (k > 0) chk("t3_gap", 32'(cyc), 32'd2);
            if (idx >= 0) data[idx] = 16'($urandom);
        end
        req_valid = 4'b0011; req_lock = 4'b0010;
        wait_grant(idx, cyc);
        chk("t4_first", 32'(idx), 32'd1);
        wait_grant(idx, cyc);
        chk("t4_locked", 32'(idx), 32'd1);
        req_valid = 4'b0001; req_lock = 0;
        wait_grant(idx, cyc);
        chk("t4_after_drop", 32'(idx), 32'd0);
        req_valid = 4'b0001; data[0] = 16'h1234;
        @(posedge clock);
        #1;
        wait_grant(idx, cyc);
        chk("t5_grant", 32'(idx), 32'd0);
        reset_n = 0; req_valid = 0;
        @(negedge clock);
        chk("t5_rst_busy", 32'(busy), 32'd1);
        chk("t5_rst_dv", 32'(data_valid), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1;
        @(negedge clock);
        chk("t5_clear_busy", 32'(busy), 32'd1);
        @(negedge clock);
        chk("t5_rd", 32'(rd_data), 32'h0);
        chk("t5_cnt", 32'(wr_count), 32'd0);
        chk("t5_lw", 32'(last_writer), 32'd0);
        @(posedge clock);
        #1 req_valid = 4'b1111;
        for (int k = 0; k < 256; k++) begin
            wait_grant(idx, cyc);
            chk("t6_grant", 32'(idx), 32'(k % 4));
            if (k > 0) chk("t6_gap", 32'(cyc), 32'd2);
            if (idx >= 0) data[idx] = 16'($urandom);
        end
        req_valid = 0;
        @(negedge clock);
        @(negedge clock);
        chk("t6_wrap", 32'(wr_count), 32'd0);
        chk("t6_lw", 32'(last_writer), 32'd3);
        repeat (1500) begin
            @(posedge clock);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (m_acc[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom % 3) != 0;
                    req_lock[i]  = ($urandom % 4) == 0;
                    data[i]      = 16'($urandom);
                end else if (ph != M_IDLE && ($urandom % 8) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
